// File: rtl/rv_sdram_bridge.sv
// rv_sdram_bridge: splits 32-bit valid/ready CPU accesses into low/high halfword
// toggle-handshake transactions on the RV port of the SDRAM controller.
module rv_sdram_bridge #(
   parameter int ACK_DATA_DELAY = 1,
   parameter bit SKIP_UNSTROBED = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic [19:0] rv_addr,
   output logic [15:0] rv_din,
   output logic [1:0]  rv_ds,
   output logic        rv_we,
   output logic        rv_req,
   input  logic        rv_req_ack,
   input  logic [15:0] rv_dout
);
   typedef enum logic [2:0] {
      S_IDLE, S_LO_ISSUE, S_LO_WAIT, S_LO_DATA,
      S_HI_ISSUE, S_HI_WAIT, S_HI_DATA, S_DONE
   } state_t;
   state_t      r_state, w_next;
   logic [20:2] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [1:0]  r_cnt;
   logic [15:0] r_lo;
   logic        r_req;
   logic [19:0] r_rv_addr;
   logic [15:0] r_rv_din;
   logic [1:0]  r_rv_ds;
   logic        r_rv_we;
   logic [31:0] r_rdata;
   logic        w_wr, w_ack, w_cnt_done, w_start, w_lo_start, w_hi_need;
   logic        w_issue_lo, w_issue_hi, w_load_cnt, w_cap_lo, w_cap_hi;
   logic        w_unused;
   assign w_unused   = ^{mem_addr[31:21], mem_addr[1:0]};
   assign w_wr       = |r_wstrb;
   assign w_ack      = (rv_req_ack == r_req);
   assign w_cnt_done = (r_cnt == 2'd0);
   assign w_start    = mem_valid && !mem_ready;
   assign w_lo_start = (mem_wstrb == 4'd0) || (|mem_wstrb[1:0]) || !SKIP_UNSTROBED;
   assign w_hi_need  = !w_wr || (|r_wstrb[3:2]) || !SKIP_UNSTROBED;
   assign mem_rdata  = r_rdata;
   assign rv_addr    = r_rv_addr;
   assign rv_din     = r_rv_din;
   assign rv_ds      = r_rv_ds;
   assign rv_we      = r_rv_we;
   assign rv_req     = r_req;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   // Writes never enter the DATA states; they leave WAIT straight on the ack match.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (w_start) w_next = w_lo_start ? S_LO_ISSUE : S_HI_ISSUE;
         S_LO_ISSUE: w_next = S_LO_WAIT;
         S_LO_WAIT:  if (w_ack) w_next = !w_wr ? S_LO_DATA : (w_hi_need ? S_HI_ISSUE : S_DONE);
         S_LO_DATA:  if (w_cnt_done) w_next = S_HI_ISSUE;
         S_HI_ISSUE: w_next = S_HI_WAIT;
         S_HI_WAIT:  if (w_ack) w_next = w_wr ? S_DONE : S_HI_DATA;
         S_HI_DATA:  if (w_cnt_done) w_next = S_DONE;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_issue_lo = (r_state == S_LO_ISSUE);
      w_issue_hi = (r_state == S_HI_ISSUE);
      w_load_cnt = ((r_state == S_LO_WAIT) || (r_state == S_HI_WAIT)) && w_ack;
      w_cap_lo   = (r_state == S_LO_DATA) && w_cnt_done;
      w_cap_hi   = (r_state == S_HI_DATA) && w_cnt_done;
      mem_ready  = (r_state == S_DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_cnt     <= '0;
         r_lo      <= '0;
         r_req     <= 1'b0;
         r_rv_addr <= '0;
         r_rv_din  <= '0;
         r_rv_ds   <= '0;
         r_rv_we   <= 1'b0;
         r_rdata   <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_start) begin
            r_addr  <= mem_addr[20:2];
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
         end
         if (w_issue_lo || w_issue_hi) begin
            r_req     <= ~r_req;
            r_rv_addr <= {r_addr, w_issue_hi};
            r_rv_din  <= w_issue_hi ? r_wdata[31:16] : r_wdata[15:0];
            r_rv_ds   <= !w_wr ? 2'b11 : (w_issue_hi ? r_wstrb[3:2] : r_wstrb[1:0]);
            r_rv_we   <= w_wr;
         end
         if (w_load_cnt) r_cnt <= 2'(ACK_DATA_DELAY - 1);
         else if (!w_cnt_done) r_cnt <= r_cnt - 2'd1;
         if (w_cap_lo) r_lo <= rv_dout;
         // mem_rdata only changes when the whole word is in, so it holds between reads.
         if (w_cap_hi) r_rdata <= {rv_dout, r_lo};
      end
   end
endmodule

// File: tb/tb_rv_sdram_bridge.sv
// tb_rv_sdram_bridge: directed bench with a behavioural toggle-handshake controller.
module tb_rv_sdram_bridge;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [19:0] rv_addr;
   logic [15:0] rv_din;
   logic [1:0]  rv_ds;
   logic        rv_we;
   logic        rv_req;
   logic        rv_req_ack;
   logic [15:0] rv_dout;

   int total = 0;
   int bad = 0;

   rv_sdram_bridge #(.ACK_DATA_DELAY(1), .SKIP_UNSTROBED(1'b1)) dut (
      .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .rv_addr(rv_addr), .rv_din(rv_din), .rv_ds(rv_ds),
      .rv_we(rv_we), .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout)
   );

   always #5 clk = ~clk;

   // Controller model: acks ack_delay+1 cycles after the toggle, memory indexed by rv_addr[9:0].
   logic [15:0] mem [0:1023];
   int          ack_delay = 0;
   int          wcnt = 0;
   int          unstable = 0;
   logic [38:0] held = '0;
   logic [38:0] log_q [$];
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rv_req_ack <= 1'b0;
         rv_dout    <= '0;
         wcnt       <= 0;
         for (int i = 0; i < 1024; i++) mem[i] <= (i == 0) ? 16'hBEEF : (i == 1) ? 16'hDEAD : 16'h0;
      end else if (rv_req != rv_req_ack) begin
         if (wcnt == 0) held <= {rv_addr, rv_din, rv_ds, rv_we};
         else if ({rv_addr, rv_din, rv_ds, rv_we} != held) unstable <= unstable + 1;
         if (wcnt >= ack_delay) begin
            rv_req_ack <= rv_req;
            wcnt <= 0;
            log_q.push_back({rv_addr, rv_din, rv_ds, rv_we});
            if (rv_we) mem[rv_addr[9:0]] <= {rv_ds[1] ? rv_din[15:8] : mem[rv_addr[9:0]][15:8],
                                             rv_ds[0] ? rv_din[7:0]  : mem[rv_addr[9:0]][7:0]};
            else rv_dout <= mem[rv_addr[9:0]];
         end else wcnt <= wcnt + 1;
      end
   end

   int   ntog = 0;
   int   nready = 0;
   logic prev_req = 1'b0;
   always @(posedge clk) begin
      if (rv_req !== prev_req) ntog <= ntog + 1;
      prev_req <= rv_req;
      if (mem_ready) nready <= nready + 1;
   end

   task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            output logic [31:0] rd, output int lat);
      repeat (2) @(negedge clk);
      mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (mem_ready) break;
      end
      rd = mem_rdata;
      mem_valid = 1'b0; mem_wstrb = '0; mem_wdata = '0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk); #1;
      total++; if ({mem_ready, mem_rdata, rv_addr, rv_din, rv_ds, rv_we, rv_req} !== '0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0", {mem_ready, mem_rdata, rv_addr, rv_din, rv_ds, rv_we, rv_req}); end
      @(negedge clk); resetn = 1'b1;
      repeat (2) @(posedge clk); #1;
      total++; if ({mem_ready, rv_req} !== 2'b00) begin
         bad++; $display("FAIL reset_idle got=%b exp=00", {mem_ready, rv_req}); end
   endtask

   task automatic test_read;
      logic [31:0] rd; int lat; int t0, l0, n0;
      t0 = ntog; l0 = log_q.size(); n0 = nready;
      do_access(32'h0008_0000, 32'h0, 4'b0000, rd, lat);
      repeat (3) @(posedge clk); #1;
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h exp=deadbeef", rd); end
      total++; if (lat !== 9) begin bad++; $display("FAIL read_latency got=%0d exp=9", lat); end
      total++; if (log_q[l0] !== {20'h40000, 16'h0, 2'b11, 1'b0}) begin
         bad++; $display("FAIL read_lo_req got=%h exp=%h", log_q[l0], {20'h40000, 16'h0, 2'b11, 1'b0}); end
      total++; if (log_q[l0+1] !== {20'h40001, 16'h0, 2'b11, 1'b0}) begin
         bad++; $display("FAIL read_hi_req got=%h exp=%h", log_q[l0+1], {20'h40001, 16'h0, 2'b11, 1'b0}); end
      total++; if (nready - n0 !== 1) begin bad++; $display("FAIL read_ready_pulses got=%0d exp=1", nready - n0); end
      total++; if (ntog - t0 !== 2) begin bad++; $display("FAIL read_toggles got=%0d exp=2", ntog - t0); end
      total++; if (mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_hold got=%h exp=deadbeef", mem_rdata); end
   endtask

   task automatic test_write;
      logic [31:0] rd; int lat; int l0;
      l0 = log_q.size();
      do_access(32'h0000_0010, 32'h12345678, 4'b1111, rd, lat);
      total++; if (lat !== 7) begin bad++; $display("FAIL write_latency got=%0d exp=7", lat); end
      total++; if (log_q[l0] !== {20'h00008, 16'h5678, 2'b11, 1'b1}) begin
         bad++; $display("FAIL write_lo_req got=%h exp=%h", log_q[l0], {20'h00008, 16'h5678, 2'b11, 1'b1}); end
      total++; if (log_q[l0+1] !== {20'h00009, 16'h1234, 2'b11, 1'b1}) begin
         bad++; $display("FAIL write_hi_req got=%h exp=%h", log_q[l0+1], {20'h00009, 16'h1234, 2'b11, 1'b1}); end
      total++; if (mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL write_keeps_rdata got=%h exp=deadbeef", mem_rdata); end
      do_access(32'h0000_0010, 32'h0, 4'b0000, rd, lat);
      total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL write_readback got=%h exp=12345678", rd); end
   endtask

   task automatic test_byte_write;
      logic [31:0] rd; int lat; int t0, l0;
      t0 = ntog; l0 = log_q.size();
      do_access(32'h0000_0020, 32'h00AB0000, 4'b0100, rd, lat);
      @(posedge clk); #1;
      total++; if (lat !== 4) begin bad++; $display("FAIL byte_latency got=%0d exp=4", lat); end
      total++; if (ntog - t0 !== 1) begin bad++; $display("FAIL byte_toggles got=%0d exp=1", ntog - t0); end
      total++; if (log_q.size() - l0 !== 1) begin bad++; $display("FAIL byte_reqs got=%0d exp=1", log_q.size() - l0); end
      total++; if (log_q[l0] !== {20'h00011, 16'h00AB, 2'b01, 1'b1}) begin
         bad++; $display("FAIL byte_req got=%h exp=%h", log_q[l0], {20'h00011, 16'h00AB, 2'b01, 1'b1}); end
      l0 = log_q.size();
      do_access(32'h0000_0030, 32'hFFFF9876, 4'b0011, rd, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL lo_only_latency got=%0d exp=4", lat); end
      total++; if (log_q[l0] !== {20'h00018, 16'h9876, 2'b11, 1'b1}) begin
         bad++; $display("FAIL lo_only_req got=%h exp=%h", log_q[l0], {20'h00018, 16'h9876, 2'b11, 1'b1}); end
      do_access(32'h0000_0020, 32'h0, 4'b0000, rd, lat);
      total++; if (rd !== 32'h00AB0000) begin bad++; $display("FAIL byte_readback got=%h exp=00ab0000", rd); end
   endtask

   task automatic test_delayed_ack;
      logic [31:0] rd; int lat; int t0, l0, u0;
      ack_delay = 4; t0 = ntog; l0 = log_q.size(); u0 = unstable;
      do_access(32'h0000_0040, 32'h11223344, 4'b0101, rd, lat);
      @(posedge clk); #1;
      total++; if (lat !== 15) begin bad++; $display("FAIL slow_write_latency got=%0d exp=15", lat); end
      total++; if (ntog - t0 !== 2) begin bad++; $display("FAIL slow_toggles got=%0d exp=2", ntog - t0); end
      total++; if (unstable - u0 !== 0) begin bad++; $display("FAIL slow_stable got=%0d exp=0", unstable - u0); end
      total++; if (log_q[l0] !== {20'h00020, 16'h3344, 2'b01, 1'b1}) begin
         bad++; $display("FAIL slow_lo_req got=%h exp=%h", log_q[l0], {20'h00020, 16'h3344, 2'b01, 1'b1}); end
      total++; if (log_q[l0+1] !== {20'h00021, 16'h1122, 2'b01, 1'b1}) begin
         bad++; $display("FAIL slow_hi_req got=%h exp=%h", log_q[l0+1], {20'h00021, 16'h1122, 2'b01, 1'b1}); end
      do_access(32'h0000_0040, 32'h0, 4'b0000, rd, lat);
      total++; if (rd !== 32'h00220044) begin bad++; $display("FAIL slow_read_data got=%h exp=00220044", rd); end
      total++; if (lat !== 17) begin bad++; $display("FAIL slow_read_latency got=%0d exp=17", lat); end
      total++; if (unstable - u0 !== 0) begin bad++; $display("FAIL slow_read_stable got=%0d exp=0", unstable - u0); end
      ack_delay = 0;
   endtask

   task automatic test_wrap;
      logic [31:0] rd; int lat; int l0;
      l0 = log_q.size();
      do_access(32'hFFE8_0000, 32'h0, 4'b0000, rd, lat);
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL wrap_data got=%h exp=deadbeef", rd); end
      total++; if (log_q[l0][38:19] !== 20'h40000) begin
         bad++; $display("FAIL wrap_addr got=%h exp=40000", log_q[l0][38:19]); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd; int lat; int t0, l0;
      t0 = ntog; l0 = log_q.size();
      do_access(32'h0000_0010, 32'h0, 4'b0000, rd, lat);
      total++; if (rd !== 32'h12345678 || lat !== 9) begin
         bad++; $display("FAIL b2b_read got=%h/%0d exp=12345678/9", rd, lat); end
      do_access(32'h0000_0050, 32'hCAFEF00D, 4'b1111, rd, lat);
      @(posedge clk); #1;
      total++; if (lat !== 7) begin bad++; $display("FAIL b2b_write_latency got=%0d exp=7", lat); end
      total++; if (ntog - t0 !== 4) begin bad++; $display("FAIL b2b_toggles got=%0d exp=4", ntog - t0); end
      total++; if (log_q[l0+2] !== {20'h00028, 16'hF00D, 2'b11, 1'b1}) begin
         bad++; $display("FAIL b2b_lo_req got=%h exp=%h", log_q[l0+2], {20'h00028, 16'hF00D, 2'b11, 1'b1}); end
      total++; if (log_q[l0+3] !== {20'h00029, 16'hCAFE, 2'b11, 1'b1}) begin
         bad++; $display("FAIL b2b_hi_req got=%h exp=%h", log_q[l0+3], {20'h00029, 16'hCAFE, 2'b11, 1'b1}); end
   endtask

   task automatic test_reset_midway;
      logic [31:0] rd; int lat; logic r0;
      ack_delay = 4; r0 = rv_req;
      repeat (2) @(negedge clk);
      mem_valid = 1'b1; mem_addr = 32'h0000_0040; mem_wdata = '0; mem_wstrb = 4'b0000;
      repeat (3) @(posedge clk); #1;
      total++; if ({rv_req, rv_addr} !== {~r0, 20'h00020}) begin
         bad++; $display("FAIL midway_issued got=%h exp=%h", {rv_req, rv_addr}, {~r0, 20'h00020}); end
      #2 resetn = 1'b0;
      #1;
      total++; if ({mem_ready, mem_rdata, rv_addr, rv_din, rv_ds, rv_we, rv_req} !== '0) begin
         bad++; $display("FAIL midway_reset got=%h exp=0", {mem_ready, mem_rdata, rv_addr, rv_din, rv_ds, rv_we, rv_req}); end
      mem_valid = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1; ack_delay = 0;
      do_access(32'h0008_0000, 32'h0, 4'b0000, rd, lat);
      total++; if (rd !== 32'hDEADBEEF || lat !== 9) begin
         bad++; $display("FAIL midway_recover got=%h/%0d exp=deadbeef/9", rd, lat); end
   endtask

   initial begin
      test_reset;
      test_read;
      test_write;
      test_byte_write;
      test_delayed_ack;
      test_wrap;
      test_back_to_back;
      test_reset_midway;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
